// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and widths for the data memory arbiter
package dmem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 8;

    typedef enum logic {
        ARB,
        LOCK
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_AUX
    } owner_t;

endpackage

// File: rtl/dmem_arb_sat_ctr.sv
// rtl/dmem_arb_sat_ctr.sv - saturating up-counter with clear and at-max flag
module dmem_arb_sat_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [CNT_W-1:0] cnt;

    assign at_max = (cnt == CNT_W'(MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data memory arbiter with bounded AUX wait and locked bursts
// Optional grant/conflict counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [BE_W-1:0]   cpu_be,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              aux_req,
    input  logic              aux_lock,
    input  logic              aux_we,
    input  logic [BE_W-1:0]   aux_be,
    input  logic [DATA_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_ack,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu_grants,
    output logic [31:0]       stat_aux_grants,
    output logic [31:0]       stat_conflicts
`endif
);

    arb_state_t state_q, state_d;
    owner_t     owner;
    logic       wait_max;
    logic       lock_last_beat;
    logic       lock_exit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant is forced to none while reset is high so no access or write can leak out.
    always_comb begin
        owner   = OWN_NONE;
        state_d = state_q;
        if (!reset) begin
            case (state_q)
                ARB: begin
                    if (aux_req && (!cpu_req || wait_max)) begin
                        owner = OWN_AUX;
                    end else if (cpu_req) begin
                        owner = OWN_CPU;
                    end
                    if (owner == OWN_AUX && aux_lock && !lock_last_beat) begin
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (aux_req) begin
                        owner = OWN_AUX;
                    end
                    if (!aux_req || !aux_lock || lock_last_beat) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    assign cpu_ack   = (owner == OWN_CPU);
    assign aux_ack   = (owner == OWN_AUX);
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign cpu_rdata = cpu_ack ? mem_rdata : '0;
    assign aux_rdata = aux_ack ? mem_rdata : '0;
    assign lock_exit = (state_q == LOCK) && (state_d == ARB);

    dmem_arb_sat_ctr #(.MAX(MAX_WAIT)) u_wait_ctr (
        .clk    (clk),
        .reset  (reset),
        .inc    (aux_req & ~aux_ack),
        .clr    (aux_ack | lock_exit),
        .at_max (wait_max)
    );

    // Holds beats already completed, so at_max flags the beat that brings the total to LOCK_MAX.
    dmem_arb_sat_ctr #(.MAX(LOCK_MAX - 1)) u_lock_ctr (
        .clk    (clk),
        .reset  (reset),
        .inc    (aux_ack & aux_lock),
        .clr    (state_d == ARB),
        .at_max (lock_last_beat)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (owner)
            OWN_CPU: begin
                mem_we    = cpu_we;
                mem_be    = cpu_be;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_AUX: begin
                mem_we    = aux_we;
                mem_be    = aux_be;
                mem_addr  = aux_addr;
                mem_wdata = aux_wdata;
            end
            default: ;
        endcase
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_cpu_grants <= '0;
            stat_aux_grants <= '0;
            stat_conflicts  <= '0;
        end else begin
            if (cpu_ack) stat_cpu_grants <= stat_cpu_grants + 32'd1;
            if (aux_ack) stat_aux_grants <= stat_aux_grants + 32'd1;
            if (cpu_req && aux_req) stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`endif

endmodule
